// File: rtl/snn_pkg.sv
// snn_pkg: shared configuration, types and helpers for the SNN spike readout slice.
//   T, N, CW, LANES    : neuron blocks, neurons per block, counter width, counts per beat
//   BEATS_PER_BLOCK    : output beats needed to cover one block
//   readout_state_t    : readout FSM states
//   count_t / sat_inc  : counter type and its saturating increment
// Index ports carry one bit more than $clog2 needs, so out-of-range spike addresses
// can be presented and flagged even when T and N are powers of two.
package snn_pkg;

  localparam int unsigned T     = 4;
  localparam int unsigned N     = 8;
  localparam int unsigned CW    = 8;
  localparam int unsigned LANES = 4;

  localparam int unsigned BEATS_PER_BLOCK = N / LANES;
  localparam int unsigned BEATS           = T * BEATS_PER_BLOCK;

  localparam int unsigned TW    = (T > 1) ? $clog2(T) : 1;
  localparam int unsigned NW    = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned BLK_W = TW + 1;
  localparam int unsigned NRN_W = NW + 1;
  localparam int unsigned IDX_W = ((T * N) > 1) ? $clog2(T * N) : 1;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned DW    = LANES * CW;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} readout_state_t;

  typedef logic [CW-1:0] count_t;

  localparam count_t CNT_MAX = '1;

  function automatic count_t sat_inc(input count_t c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/snn_spike_count_bank.sv
// snn_spike_count_bank: T*N saturating spike counters, stored block-major
// (flat index = block*N + neuron), so beat b covers flat indices b*LANES .. b*LANES+LANES-1.
//   clk, reset      : clock, asynchronous active-high reset (all counters to 0)
//   inc_en_i        : increment counter inc_idx_i this cycle
//   inc_idx_i       : flat counter index for the increment
//   inc_at_max_o    : addressed counter is already saturated
//   rc_beat_i       : beat index for the read-and-clear port
//   rc_clr_i        : clear the LANES counters of rc_beat_i at the next edge
//   rc_data_o       : LANES counts of rc_beat_i, lane k at [k*CW +: CW]
module snn_spike_count_bank
  import snn_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_en_i,
  input  logic [IDX_W-1:0] inc_idx_i,
  output logic             inc_at_max_o,
  input  logic [BW-1:0]    rc_beat_i,
  input  logic             rc_clr_i,
  output logic [DW-1:0]    rc_data_o
);

  count_t cnt_q [T*N];
  count_t cnt_d [T*N];

  assign inc_at_max_o = (cnt_q[inc_idx_i] == CNT_MAX);

  always_comb begin
    rc_data_o = '0;
    for (int k = 0; k < LANES; k++) begin
      rc_data_o[k*CW +: CW] = cnt_q[IDX_W'(32'(rc_beat_i) * LANES + k)];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (inc_en_i) begin
      cnt_d[inc_idx_i] = sat_inc(cnt_q[inc_idx_i]);
    end
    // Clear wins over a same-cycle increment of the same counter.
    if (rc_clr_i) begin
      for (int k = 0; k < LANES; k++) begin
        cnt_d[IDX_W'(32'(rc_beat_i) * LANES + k)] = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < T * N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/snn_spike_readout.sv
// snn_spike_readout: per-(block,neuron) spike counter bank with an AXI-Stream drain.
// Counts spikes while time_step is high, then streams all T*N counts, LANES per beat,
// clearing each beat's counters as it is taken into the output register.
//   clk, reset            : clock, asynchronous active-high reset
//   time_step             : window enable, high = accumulate
//   spike_valid           : one spike event this cycle at (spike_block, spike_neuron)
//   m_tvalid/m_tready     : AXIS handshake
//   m_tdata / m_tlast     : LANES counts per beat / final beat of a frame
//   drop_count            : spikes seen while draining (saturating, 16 bit)
//   sat_flag, err_index   : sticky saturation / out-of-range address flags
// Optional feature, macro SNN_READOUT_TUSER_EN: adds m_tuser = block index of the beat.
module snn_spike_readout
  import snn_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             time_step,
  input  logic             spike_valid,
  input  logic [BLK_W-1:0] spike_block,
  input  logic [NRN_W-1:0] spike_neuron,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic [DW-1:0]    m_tdata,
  output logic             m_tlast,
  output logic [15:0]      drop_count,
  output logic             sat_flag,
  output logic             err_index
`ifdef SNN_READOUT_TUSER_EN
  ,
  output logic [TW-1:0]    m_tuser
`endif
);

  if ((N % LANES) != 0) begin : g_bad_lanes
    $error("snn_spike_readout: N must be a multiple of LANES");
  end

  readout_state_t   state_q, state_d;
  logic [BW-1:0]    beat_q, beat_d;     // next beat to load into the output register
  logic             tvalid_q, tvalid_d;
  logic [DW-1:0]    tdata_q, tdata_d;
  logic             tlast_q, tlast_d;
  logic [15:0]      drop_q, drop_d;
  logic             sat_q, sat_d;
  logic             err_q, err_d;
`ifdef SNN_READOUT_TUSER_EN
  logic [TW-1:0]    tuser_q, tuser_d;
`endif

  logic             in_range;
  logic             inc_en;
  logic [IDX_W-1:0] inc_idx;
  logic             at_max;
  logic             load;
  logic [DW-1:0]    rc_data;

  assign in_range = (32'(spike_block) < T) && (32'(spike_neuron) < N);
  assign inc_idx  = IDX_W'(32'(spike_block) * N + 32'(spike_neuron));

  snn_spike_count_bank u_bank (
    .clk          (clk),
    .reset        (reset),
    .inc_en_i     (inc_en),
    .inc_idx_i    (inc_idx),
    .inc_at_max_o (at_max),
    .rc_beat_i    (beat_q),
    .rc_clr_i     (load),
    .rc_data_o    (rc_data)
  );

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    drop_d   = drop_q;
    sat_d    = sat_q;
    err_d    = err_q;
`ifdef SNN_READOUT_TUSER_EN
    tuser_d  = tuser_q;
`endif
    inc_en   = 1'b0;
    load     = 1'b0;

    if (spike_valid && !in_range) begin
      err_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (time_step) begin
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        inc_en = spike_valid && in_range;
        if (inc_en && at_max) begin
          sat_d = 1'b1;
        end
        if (!time_step) begin
          state_d = DRAIN;
          beat_d  = '0;
        end
      end
      DRAIN: begin
        if (spike_valid && (drop_q != 16'hFFFF)) begin
          drop_d = drop_q + 16'd1;
        end
        // Counters are read and cleared as the beat enters the output register; nothing
        // can increment them during DRAIN, so this matches clearing at the handshake.
        load = !tvalid_q || (m_tready && !tlast_q);
        if (load) begin
          tvalid_d = 1'b1;
          tdata_d  = rc_data;
          tlast_d  = (32'(beat_q) == BEATS - 1);
          beat_d   = beat_q + 1'b1;
`ifdef SNN_READOUT_TUSER_EN
          tuser_d  = TW'(32'(beat_q) / BEATS_PER_BLOCK);
`endif
        end else if (tvalid_q && m_tready) begin
          // Handshake of the last beat closes the frame.
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          beat_d   = '0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      drop_q   <= '0;
      sat_q    <= 1'b0;
      err_q    <= 1'b0;
`ifdef SNN_READOUT_TUSER_EN
      tuser_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      drop_q   <= drop_d;
      sat_q    <= sat_d;
      err_q    <= err_d;
`ifdef SNN_READOUT_TUSER_EN
      tuser_q  <= tuser_d;
`endif
    end
  end

  assign m_tvalid   = tvalid_q;
  assign m_tdata    = tdata_q;
  assign m_tlast    = tlast_q;
  assign drop_count = drop_q;
  assign sat_flag   = sat_q;
  assign err_index  = err_q;
`ifdef SNN_READOUT_TUSER_EN
  assign m_tuser    = tuser_q;
`endif

endmodule

// File: tb/tb_snn_spike_readout.sv
// Directed self-checking bench for snn_spike_readout (default build T=4, N=8, CW=8, LANES=4).
module tb_snn_spike_readout;

  localparam int DW    = 32;
  localparam int BLK_W = 3;
  localparam int NRN_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             time_step;
  logic             spike_valid;
  logic [BLK_W-1:0] spike_block;
  logic [NRN_W-1:0] spike_neuron;
  logic             m_tvalid;
  logic             m_tready;
  logic [DW-1:0]    m_tdata;
  logic             m_tlast;
  logic [15:0]      drop_count;
  logic             sat_flag;
  logic             err_index;
`ifdef SNN_READOUT_TUSER_EN
  logic [1:0]       m_tuser;
`endif

  always #5 clk = ~clk;

  snn_spike_readout dut (
    .clk          (clk),
    .reset        (reset),
    .time_step    (time_step),
    .spike_valid  (spike_valid),
    .spike_block  (spike_block),
    .spike_neuron (spike_neuron),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tdata      (m_tdata),
    .m_tlast      (m_tlast),
    .drop_count   (drop_count),
    .sat_flag     (sat_flag),
    .err_index    (err_index)
`ifdef SNN_READOUT_TUSER_EN
    ,
    .m_tuser      (m_tuser)
`endif
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] got_data [16];
  logic        got_last [16];
  logic [31:0] got_user [16];
  logic [31:0] exp_data [8];
  int          n_beats;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic spike(input int b, input int n);
    spike_valid  = 1'b1;
    spike_block  = BLK_W'(b);
    spike_neuron = NRN_W'(n);
    step();
    spike_valid  = 1'b0;
  endtask

  task automatic open_window();
    time_step = 1'b1;
    step();
  endtask

  task automatic close_window();
    time_step = 1'b0;
    step();
  endtask

  // Flat counter f = block*8 + neuron receives f+1 spikes.
  task automatic fill_distinct();
    open_window();
    for (int f = 0; f < 32; f++) begin
      repeat (f + 1) spike(f / 8, f % 8);
    end
    close_window();
    for (int b = 0; b < 8; b++) begin
      exp_data[b] = '0;
      for (int k = 0; k < 4; k++) exp_data[b][k*8 +: 8] = 8'(b * 4 + k + 1);
    end
  endtask

  task automatic set_exp_all(input logic [31:0] v);
    for (int b = 0; b < 8; b++) exp_data[b] = v;
  endtask

  // mode 0: tready always 1; mode 1: tready pattern 1,0,0,1,0,0,...
  task automatic drain(input int mode, input int max_beats);
    int          cyc;
    bit          done;
    bit          held;
    logic [31:0] sd;
    logic        sl;
    cyc = 0; done = 0; held = 0; sd = '0; sl = 1'b0;
    n_beats = 0;
    for (int i = 0; i < 16; i++) begin
      got_data[i] = 32'hDEADBEEF;
      got_last[i] = 1'bx;
      got_user[i] = 32'hDEADBEEF;
    end
    while (!done && n_beats < max_beats && cyc < 200) begin
      m_tready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      if (held) begin
        check_val("stall_valid", 32'(m_tvalid), 32'd1);
        check_val("stall_data", m_tdata, sd);
        check_val("stall_last", 32'(m_tlast), 32'(sl));
      end
      held = m_tvalid && !m_tready;
      sd   = m_tdata;
      sl   = m_tlast;
      if (m_tvalid && m_tready && n_beats < 16) begin
        got_data[n_beats] = m_tdata;
        got_last[n_beats] = m_tlast;
`ifdef SNN_READOUT_TUSER_EN
        got_user[n_beats] = 32'(m_tuser);
`endif
        n_beats++;
        if (m_tlast) done = 1;
      end
      step();
      cyc++;
    end
    check_val("drain_in_budget", 32'(cyc < 200), 32'd1);
  endtask

  task automatic check_frame(input string tn, input int nb);
    check_val($sformatf("%s nbeats", tn), 32'(n_beats), 32'(nb));
    for (int b = 0; b < nb; b++) begin
      check_val($sformatf("%s beat%0d data", tn, b), got_data[b], exp_data[b]);
      check_val($sformatf("%s beat%0d last", tn, b), 32'(got_last[b]), 32'(b == 7));
`ifdef SNN_READOUT_TUSER_EN
      check_val($sformatf("%s beat%0d tuser", tn, b), got_user[b], 32'(b / 2));
`endif
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    time_step    = 1'b0;
    spike_valid  = 1'b0;
    spike_block  = '0;
    spike_neuron = '0;
    m_tready     = 1'b1;
    #2;
    check_val("rst tvalid", 32'(m_tvalid), 32'd0);
    check_val("rst tdata", m_tdata, 32'd0);
    check_val("rst tlast", 32'(m_tlast), 32'd0);
    check_val("rst drop", 32'(drop_count), 32'd0);
    check_val("rst sat", 32'(sat_flag), 32'd0);
    check_val("rst err", 32'(err_index), 32'd0);
    step();
    step();
    reset = 1'b0;
    step();

    // T1: three spikes to (0,0), the third in the same cycle time_step falls.
    open_window();
    spike(0, 0);
    spike(0, 0);
    time_step = 1'b0;
    spike(0, 0);
    set_exp_all(32'h0);
    exp_data[0] = 32'h00000003;
    drain(0, 16);
    check_frame("T1", 8);
    check_val("T1 tvalid_after", 32'(m_tvalid), 32'd0);
    check_val("T1 sat", 32'(sat_flag), 32'd0);

    // T2: 300 spikes to (2,5) saturate at FF -> beat 5 lane 1.
    open_window();
    repeat (300) spike(2, 5);
    close_window();
    set_exp_all(32'h0);
    exp_data[5] = 32'h0000FF00;
    drain(0, 16);
    check_frame("T2", 8);
    check_val("T2 sat", 32'(sat_flag), 32'd1);

    // T3: one spike per neuron, stalled drain.
    open_window();
    for (int b = 0; b < 4; b++) begin
      for (int n = 0; n < 8; n++) spike(b, n);
    end
    close_window();
    set_exp_all(32'h01010101);
    drain(1, 16);
    check_frame("T3", 8);
    check_val("T3 tvalid_after", 32'(m_tvalid), 32'd0);

    // T3b: distinct counts check lane/beat ordering.
    fill_distinct();
    drain(0, 16);
    check_frame("T3b", 8);

    // T4: spikes during DRAIN are dropped; next frame drains zeros.
    m_tready = 1'b0;
    open_window();
    close_window();
    repeat (5) spike(1, 1);
    set_exp_all(32'h0);
    drain(0, 16);
    check_frame("T4a", 8);
    check_val("T4 drop", 32'(drop_count), 32'd5);
    check_val("T4 err", 32'(err_index), 32'd0);
    open_window();
    close_window();
    drain(0, 16);
    check_frame("T4b", 8);
    check_val("T4 drop_hold", 32'(drop_count), 32'd5);

    // T5: out-of-range block and neuron in ACCUM.
    open_window();
    spike(4, 0);
    spike(0, 8);
    close_window();
    set_exp_all(32'h0);
    drain(0, 16);
    check_frame("T5", 8);
    check_val("T5 err", 32'(err_index), 32'd1);
    check_val("T5 drop", 32'(drop_count), 32'd5);
    check_val("T5 sat_sticky", 32'(sat_flag), 32'd1);

    // T6: reset right after the beat 3 handshake.
    fill_distinct();
    drain(0, 4);
    check_frame("T6a", 4);
    check_val("T6 tvalid_pre", 32'(m_tvalid), 32'd1);
    reset = 1'b1;
    #1;
    check_val("T6 tvalid_rst", 32'(m_tvalid), 32'd0);
    check_val("T6 tdata_rst", m_tdata, 32'd0);
    check_val("T6 drop_rst", 32'(drop_count), 32'd0);
    check_val("T6 sat_rst", 32'(sat_flag), 32'd0);
    check_val("T6 err_rst", 32'(err_index), 32'd0);
    step();
    reset = 1'b0;
    step();
    open_window();
    close_window();
    set_exp_all(32'h0);
    drain(0, 16);
    check_frame("T6b", 8);
    check_val("T6 tvalid_after", 32'(m_tvalid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
